// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, tx state encoding
// and the clock-to-baud divisor helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } tx_state_t;

  function automatic int baud_div(
    input int clk_hz,
    input int baud
  );
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO: push/pop on clk, registered level/full.
// Ports: clk, rst_n, push, pop, din, dout (head), full, empty, level.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_n;
  logic          full_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level_q == '0);
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty;

  always_comb begin
    level_n = level_q;
    if (do_push && !do_pop)
      level_n = level_q + LW'(1);
    else if (do_pop && !do_push)
      level_n = level_q - LW'(1);
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_n;
      full_q  <= (level_n == LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = full_q;
  assign level = level_q;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter: FIFO in, configurable N/O/E, 1-2 stop.
// Ports: i_clk, i_rst_n, i_data/i_valid/o_ready, o_busy, o_level, uart_txd.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
)(
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          uart_txd
);

  localparam int  DIV     = baud_div(CLK_HZ, BAUD);
  localparam int  CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam bit  HAS_PAR = (PARITY != PAR_NONE);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("DATA_W must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("CLK_HZ/BAUD divisor must be at least 2");
  end

  logic [DATA_W-1:0] f_dout;
  logic              f_full;
  logic              f_empty;
  logic              pop;

  uart_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (i_valid),
    .pop   (pop),
    .din   (i_data),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .level (o_level)
  );

  tx_state_t         state_q, state_n;
  logic [CW-1:0]     baud_q, baud_n;
  logic [3:0]        bit_q, bit_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              par_q, par_n;
  logic              txd_q, line;
  logic              busy_q;
  logic              tick;
  logic              par_load;

  assign tick = (baud_q == CW'(DIV - 1));

  // Odd mode inverts the xor so data ones + parity is odd.
  assign par_load = (PARITY == PAR_ODD) ? ~^f_dout : ^f_dout;

  always_comb begin
    state_n = state_q;
    baud_n  = tick ? '0 : baud_q + CW'(1);
    bit_n   = bit_q;
    shift_n = shift_q;
    par_n   = par_q;
    pop     = 1'b0;
    line    = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        baud_n = '0;
        pop    = !f_empty;
      end
      S_START: begin
        line = 1'b0;
        if (tick) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        line = shift_q[0];
        if (tick) begin
          shift_n = shift_q >> 1;
          bit_n   = bit_q + 4'd1;
          if (bit_q == 4'(DATA_W - 1)) begin
            state_n = HAS_PAR ? S_PAR : S_STOP;
            bit_n   = '0;
          end
        end
      end
      S_PAR: begin
        line = par_q;
        if (tick) begin
          state_n = S_STOP;
          bit_n   = '0;
        end
      end
      S_STOP: begin
        if (tick) begin
          bit_n = bit_q + 4'd1;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            state_n = S_IDLE;
            pop     = !f_empty;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Loading from IDLE or the final stop cycle gives
    // back-to-back frames with no idle gap.
    if (pop) begin
      state_n = S_START;
      shift_n = f_dout;
      par_n   = par_load;
      bit_n   = '0;
      baud_n  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      txd_q   <= line;
      busy_q  <= (state_q != S_IDLE) || (o_level != '0);
    end
  end

  assign uart_txd = txd_q;
  assign o_busy   = busy_q;
  assign o_ready  = !f_full;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Self-checking bench for uart_tx_fifo_param: four parameter sets,
// frames decoded from the line and matched against a scoreboard.
module tb_uart_tx_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] din;
  logic [3:0] vld;
  logic [3:0] rdy;
  logic [3:0] bsy;
  logic [3:0] txd;
  logic [2:0] lvl0, lvl1, lvl2, lvl3;
  logic [1:0] sel;
  logic       line;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb line = txd[sel];

  uart_tx_fifo_param #(
    .CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_W(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din[7:0]),
    .i_valid(vld[0]), .o_ready(rdy[0]), .o_busy(bsy[0]),
    .o_level(lvl0), .uart_txd(txd[0])
  );

  uart_tx_fifo_param #(
    .CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_W(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din[7:0]),
    .i_valid(vld[1]), .o_ready(rdy[1]), .o_busy(bsy[1]),
    .o_level(lvl1), .uart_txd(txd[1])
  );

  uart_tx_fifo_param #(
    .CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_W(8),
    .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_o (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din[7:0]),
    .i_valid(vld[2]), .o_ready(rdy[2]), .o_busy(bsy[2]),
    .o_level(lvl2), .uart_txd(txd[2])
  );

  uart_tx_fifo_param #(
    .DATA_W(9)
  ) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din),
    .i_valid(vld[3]), .o_ready(rdy[3]), .o_busy(bsy[3]),
    .o_level(lvl3), .uart_txd(txd[3])
  );

  typedef struct {
    logic [8:0] d;
    logic       p;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic push_sb(input logic [8:0] d, input int dw,
                         input int par);
    exp_t e;
    int   ones;
    ones = 0;
    e.d  = '0;
    for (int i = 0; i < dw; i++) begin
      e.d[i] = d[i];
      if (d[i]) ones++;
    end
    if (par == 1) e.p = (ones % 2 == 0);
    else          e.p = (ones % 2 == 1);
    sb.push_back(e);
  endtask

  task automatic push1(input int which, input logic [8:0] d,
                       output int n);
    @(negedge clk);
    din        = d;
    vld[which] = 1'b1;
    @(negedge clk);
    vld[which] = 1'b0;
    n = cyc;
  endtask

  task automatic rx_frame(input string tag, input int dw,
                          input int par, input int stop,
                          input int div, output int st,
                          output int en);
    logic [15:0] bits;
    logic [8:0]  got;
    logic        v;
    bit          glitch;
    bit          stop_ok;
    int          n, t;
    exp_t        e;
    n = 1 + dw + ((par != 0) ? 1 : 0) + stop;
    t = 0;
    @(negedge clk);
    while (line !== 1'b0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (line !== 1'b0) begin
      n_chk++;
      $display("FAIL %s start_timeout line=%b want 0", tag, line);
      st = -1;
      en = -1;
      return;
    end
    st     = cyc;
    glitch = 0;
    bits   = '0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < div; k++) begin
        if (i != 0 || k != 0) @(negedge clk);
        v = line;
        if (k == 0) bits[i] = v;
        else if (v !== bits[i]) glitch = 1;
      end
    end
    en = cyc;
    n_chk++;
    if (glitch) $display("FAIL %s bit_hold changed=1 want 0", tag);
    else n_pass++;
    n_chk++;
    if (bits[0] !== 1'b0)
      $display("FAIL %s start_bit got=%b want 0", tag, bits[0]);
    else n_pass++;
    stop_ok = 1;
    for (int j = 0; j < stop; j++)
      if (bits[n-1-j] !== 1'b1) stop_ok = 0;
    n_chk++;
    if (!stop_ok)
      $display("FAIL %s stop_bits got=%b want all 1", tag, bits);
    else n_pass++;
    got = '0;
    for (int i = 0; i < dw; i++) got[i] = bits[1+i];
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL %s unexpected_frame got=%h want none", tag, got);
      return;
    end
    e = sb.pop_front();
    if (got !== e.d)
      $display("FAIL %s data got=%h want %h", tag, got, e.d);
    else n_pass++;
    if (par != 0) begin
      n_chk++;
      if (bits[dw+1] !== e.p)
        $display("FAIL %s parity got=%b want %b", tag,
                 bits[dw+1], e.p);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    int lows;
    rst_n = 1'b0;
    vld   = '0;
    din   = '0;
    sel   = 2'd0;
    repeat (5) @(negedge clk);
    n_chk++;
    if (txd[0] !== 1'b1)
      $display("FAIL rst_txd got=%b want 1", txd[0]);
    else n_pass++;
    n_chk++;
    if (bsy[0] !== 1'b0)
      $display("FAIL rst_busy got=%b want 0", bsy[0]);
    else n_pass++;
    n_chk++;
    if (rdy[0] !== 1'b1)
      $display("FAIL rst_ready got=%b want 1", rdy[0]);
    else n_pass++;
    n_chk++;
    if (lvl0 !== 3'd0)
      $display("FAIL rst_level got=%0d want 0", lvl0);
    else n_pass++;
    rst_n = 1'b1;
    lows  = 0;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 4'hF) lows++;
    end
    n_chk++;
    if (lows !== 0)
      $display("FAIL rst_idle_line low_cycles=%0d want 0", lows);
    else n_pass++;
    n_chk++;
    if (bsy !== 4'h0)
      $display("FAIL rst_idle_busy got=%b want 0000", bsy);
    else n_pass++;
  endtask

  task automatic test_8n1();
    int n, st, en;
    sel = 2'd0;
    push1(0, 9'h0A5, n);
    push_sb(9'h0A5, 8, 0);
    rx_frame("8n1", 8, 0, 1, 10, st, en);
    n_chk++;
    if (st !== n + 2)
      $display("FAIL 8n1_latency start=%0d want %0d", st, n + 2);
    else n_pass++;
    n_chk++;
    if (en - st + 1 !== 100)
      $display("FAIL 8n1_length got=%0d want 100", en - st + 1);
    else n_pass++;
    n_chk++;
    if (bsy[0] !== 1'b1)
      $display("FAIL 8n1_busy_hold got=%b want 1", bsy[0]);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bsy[0] !== 1'b0 || cyc !== n + 102)
      $display("FAIL 8n1_busy_fall got=%b@%0d want 0@%0d",
               bsy[0], cyc, n + 102);
    else n_pass++;
  endtask

  task automatic test_parity();
    int n, st, en;
    sel = 2'd1;
    push1(1, 9'h007, n);
    push_sb(9'h007, 8, 2);
    rx_frame("even", 8, 2, 1, 10, st, en);
    n_chk++;
    if (en - st + 1 !== 110)
      $display("FAIL even_length got=%0d want 110", en - st + 1);
    else n_pass++;
    sel = 2'd2;
    push1(2, 9'h007, n);
    push_sb(9'h007, 8, 1);
    rx_frame("odd2s", 8, 1, 2, 10, st, en);
    n_chk++;
    if (st !== n + 2 || en - st + 1 !== 120)
      $display("FAIL odd2s_timing start=%0d len=%0d want %0d/120",
               st, en - st + 1, n + 2);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_burst();
    logic [7:0] w [6];
    int         acc [6];
    int         st_a [6];
    int         idx, t, en;
    bit         hs, ok;
    w = '{8'h11, 8'h22, 8'h3C, 8'hC3, 8'h5A, 8'hF0};
    foreach (acc[i]) acc[i] = -1;
    sel = 2'd0;
    fork
      begin
        idx = 0;
        t   = 0;
        @(negedge clk);
        din    = {1'b0, w[0]};
        vld[0] = 1'b1;
        while (idx < 6 && t < 1000) begin
          hs = rdy[0];
          @(negedge clk);
          t++;
          if (hs) begin
            acc[idx] = cyc;
            push_sb({1'b0, w[idx]}, 8, 0);
            idx++;
            if (idx == 5) begin
              n_chk++;
              if (rdy[0] !== 1'b0 || lvl0 !== 3'd4)
                $display("FAIL burst_full ready=%b level=%0d want 0/4",
                         rdy[0], lvl0);
              else n_pass++;
            end
            if (idx < 6) din = {1'b0, w[idx]};
            else vld[0] = 1'b0;
          end
        end
        vld[0] = 1'b0;
        n_chk++;
        if (idx !== 6)
          $display("FAIL burst_accept_timeout got=%0d want 6", idx);
        else n_pass++;
      end
      begin
        for (int i = 0; i < 6; i++)
          rx_frame("burst", 8, 0, 1, 10, st_a[i], en);
      end
    join
    ok = 1;
    for (int k = 1; k < 5; k++)
      if (acc[k] !== acc[0] + k) ok = 0;
    n_chk++;
    if (!ok)
      $display("FAIL burst_consecutive acc4=%0d want %0d",
               acc[4], acc[0] + 4);
    else n_pass++;
    n_chk++;
    if (acc[5] !== acc[0] + 102)
      $display("FAIL burst_sixth got=%0d want %0d",
               acc[5], acc[0] + 102);
    else n_pass++;
    n_chk++;
    if (st_a[0] !== acc[0] + 2)
      $display("FAIL burst_first_start got=%0d want %0d",
               st_a[0], acc[0] + 2);
    else n_pass++;
    ok = 1;
    for (int i = 1; i < 6; i++)
      if (st_a[i] !== st_a[i-1] + 100) ok = 0;
    n_chk++;
    if (!ok)
      $display("FAIL burst_contiguous last=%0d want %0d",
               st_a[5], st_a[0] + 500);
    else n_pass++;
    n_chk++;
    if (sb.size() !== 0)
      $display("FAIL burst_leftover got=%0d want 0", sb.size());
    else n_pass++;
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n, lows;
    sel = 2'd0;
    @(negedge clk);
    din    = 9'h000;
    vld[0] = 1'b1;
    @(negedge clk);
    n   = cyc;
    din = 9'h011;
    @(negedge clk);
    din = 9'h022;
    @(negedge clk);
    vld[0] = 1'b0;
    while (cyc < n + 45) @(negedge clk);
    n_chk++;
    if (txd[0] !== 1'b0 || lvl0 !== 3'd2)
      $display("FAIL mid_pre line=%b level=%0d want 0/2",
               txd[0], lvl0);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (txd[0] !== 1'b1 || lvl0 !== 3'd0)
      $display("FAIL mid_async line=%b level=%0d want 1/0",
               txd[0], lvl0);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows  = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) lows++;
    end
    n_chk++;
    if (lows !== 0)
      $display("FAIL mid_after low_cycles=%0d want 0", lows);
    else n_pass++;
    n_chk++;
    if (bsy[0] !== 1'b0 || lvl0 !== 3'd0 || rdy[0] !== 1'b1)
      $display("FAIL mid_state busy=%b level=%0d ready=%b want 0/0/1",
               bsy[0], lvl0, rdy[0]);
    else n_pass++;
  endtask

  task automatic test_9bit();
    int n, st, en;
    sel = 2'd3;
    push1(3, 9'h1FF, n);
    push_sb(9'h1FF, 9, 0);
    rx_frame("9bit", 9, 0, 1, 434, st, en);
    n_chk++;
    if (st !== n + 2)
      $display("FAIL 9bit_latency got=%0d want %0d", st, n + 2);
    else n_pass++;
    n_chk++;
    if (en - st + 1 !== 4774)
      $display("FAIL 9bit_length got=%0d want 4774", en - st + 1);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time=%0t want finish before", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_burst();
    test_reset_mid();
    test_9bit();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
